// File: rtl/ahb_sram_slave_if.sv
// ============================================================================
// ahb_sram_slave_if : simplified single-beat AHB-Lite bus (1-bit htrans)
// Rev 1.0
// ============================================================================
`default_nettype none

interface ahb_sram_slave_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] i_haddr;
  logic                  i_htrans;
  logic                  i_hwrite;
  logic [DATA_WIDTH-1:0] i_hwdata;
  logic [DATA_WIDTH-1:0] o_hrdata;
  logic                  o_hready;
  logic                  o_hresp;

  modport master (
    output i_haddr, i_htrans, i_hwrite, i_hwdata,
    input  o_hrdata, o_hready, o_hresp
  );

  modport slave (
    input  i_haddr, i_htrans, i_hwrite, i_hwdata,
    output o_hrdata, o_hready, o_hresp
  );
endinterface

`default_nettype wire

// File: rtl/ahb_sram_slave.sv
// ============================================================================
// ahb_sram_slave : AHB-Lite SRAM slave with configurable wait states,
//                  ERROR response on bad decode and a saturating error count
// Rev 1.0
// ============================================================================
`default_nettype none

module ahb_sram_slave #(
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    MEM_DEPTH   = 256,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
  parameter int                    WAIT_STATES = 0
) (
  input  logic            clk,
  input  logic            rst,
  ahb_sram_slave_if.slave bus,
  output logic [7:0]      o_err_cnt
);

  localparam int                    IDX_W   = $clog2(MEM_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] c_depth = ADDR_WIDTH'(MEM_DEPTH);
  localparam logic [3:0]            c_wait  = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ERR1 = 2'd2,
    S_ERR2 = 2'd3
  } state_t;

  state_t                r_state;
  logic                  r_hready;
  logic                  r_hresp;
  logic [DATA_WIDTH-1:0] r_hrdata;
  logic [7:0]            r_err_cnt;
  logic [3:0]            r_wait_cnt;
  logic                  r_wr_armed;
  logic                  r_rd_armed;
  logic [IDX_W-1:0]      r_pend_idx;
  logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

  logic [ADDR_WIDTH-1:0] w_offset;
  logic [ADDR_WIDTH-1:0] w_word;
  logic [IDX_W-1:0]      w_idx;
  logic                  w_dec_err;
  logic                  w_capture;
  logic                  w_commit;
  logic [DATA_WIDTH-1:0] w_rd_data;

  assign w_offset  = bus.i_haddr - BASE_ADDR;
  assign w_word    = w_offset >> 2;
  assign w_idx     = w_word[IDX_W-1:0];
  assign w_dec_err = (bus.i_haddr[1:0] != 2'b00) || (bus.i_haddr < BASE_ADDR) ||
                     (w_word >= c_depth);
  assign w_capture = bus.i_htrans && r_hready;

  // A write commits at the edge that closes its IDLE completion cycle.
  assign w_commit  = (r_state == S_IDLE) && r_wr_armed;
  // A read captured on that same edge must see the data being written.
  assign w_rd_data = (w_commit && (r_pend_idx == w_idx)) ? bus.i_hwdata : r_mem[w_idx];

  always_ff @(posedge clk) begin
    if (w_commit) begin
      r_mem[r_pend_idx] <= bus.i_hwdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_hready   <= 1'b1;
      r_hresp    <= 1'b0;
      r_hrdata   <= '0;
      r_err_cnt  <= 8'd0;
      r_wait_cnt <= 4'd0;
      r_wr_armed <= 1'b0;
      r_rd_armed <= 1'b0;
      r_pend_idx <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_ERR2: begin
          r_wr_armed <= 1'b0;
          r_rd_armed <= 1'b0;
          if (w_capture && w_dec_err) begin
            r_state  <= S_ERR1;
            r_hready <= 1'b0;
            r_hresp  <= 1'b1;
          end else if (w_capture) begin
            r_pend_idx <= w_idx;
            r_hresp    <= 1'b0;
            r_wr_armed <= bus.i_hwrite;
            if (WAIT_STATES == 0) begin
              r_state  <= S_IDLE;
              r_hready <= 1'b1;
              if (!bus.i_hwrite) begin
                r_hrdata <= w_rd_data;
              end
            end else begin
              r_state    <= S_WAIT;
              r_hready   <= 1'b0;
              r_wait_cnt <= c_wait;
              r_rd_armed <= !bus.i_hwrite;
            end
          end else begin
            r_state  <= S_IDLE;
            r_hready <= 1'b1;
            r_hresp  <= 1'b0;
          end
        end
        S_WAIT: begin
          if (r_wait_cnt <= 4'd1) begin
            r_state    <= S_IDLE;
            r_hready   <= 1'b1;
            r_wait_cnt <= 4'd0;
            r_rd_armed <= 1'b0;
            if (r_rd_armed) begin
              r_hrdata <= r_mem[r_pend_idx];
            end
          end else begin
            r_wait_cnt <= r_wait_cnt - 4'd1;
          end
        end
        S_ERR1: begin
          r_state  <= S_ERR2;
          r_hready <= 1'b1;
          r_hresp  <= 1'b1;
          if (r_err_cnt != 8'hFF) begin
            r_err_cnt <= r_err_cnt + 8'd1;
          end
        end
        default: begin
          r_state  <= S_IDLE;
          r_hready <= 1'b1;
          r_hresp  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_hready = r_hready;
  assign bus.o_hresp  = r_hresp;
  assign bus.o_hrdata = r_hrdata;
  assign o_err_cnt    = r_err_cnt;

endmodule

`default_nettype wire
